// File: rtl/ped_signal_controller_pkg.sv
// Shared definitions for the pedestrian signal stage.
// Holds the vehicle light codes it consumes, the pedestrian signal codes it
// drives, the per-crosswalk channel state enum and the illegal-light helper.
package tlc_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_YELLOW  = 2'b01,
    LIGHT_GREEN   = 2'b10,
    LIGHT_ILLEGAL = 2'b11
  } light_e;

  typedef enum logic [1:0] {
    PED_DONT_WALK = 2'b00,
    PED_FLASH     = 2'b01,
    PED_WALK      = 2'b10
  } ped_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WALK  = 2'b01,
    ST_FLASH = 2'b10
  } chan_state_e;

  // An illegal code on either road, or both roads showing anything but red,
  // means the upstream controller can no longer be trusted.
  function automatic logic is_conflict(input logic [1:0] ns, input logic [1:0] ew);
    return (ns == LIGHT_ILLEGAL) || (ew == LIGHT_ILLEGAL) ||
           ((ns != LIGHT_RED) && (ew != LIGHT_RED));
  endfunction

endpackage

// File: rtl/ped_signal_controller_if.sv
// Bus between the vehicle light stage / crosswalk buttons and the pedestrian
// signal stage.
//   master : drives ns_light, ew_light, ns_ped_btn, ew_ped_btn; observes outputs
//   slave  : the pedestrian controller; drives signals, lamps, pending, conflict_err
interface ped_signal_controller_if;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       ns_ped_btn;
  logic       ew_ped_btn;
  logic [1:0] ns_ped_sig;
  logic [1:0] ew_ped_sig;
  logic       ns_ped_lamp;
  logic       ew_ped_lamp;
  logic       ns_req_pending;
  logic       ew_req_pending;
  logic       conflict_err;

  modport master (
    output ns_light, ew_light, ns_ped_btn, ew_ped_btn,
    input  ns_ped_sig, ew_ped_sig, ns_ped_lamp, ew_ped_lamp,
           ns_req_pending, ew_req_pending, conflict_err
  );

  modport slave (
    input  ns_light, ew_light, ns_ped_btn, ew_ped_btn,
    output ns_ped_sig, ew_ped_sig, ns_ped_lamp, ew_ped_lamp,
           ns_req_pending, ew_req_pending, conflict_err
  );
endinterface

// File: rtl/ped_signal_controller_channel.sv
// One crosswalk channel: request latch, IDLE/WALK/FLASH sequencer and lamp drive.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   light        : vehicle light code of the parallel road
//   btn          : crosswalk push button (level)
//   force_idle   : hold the channel in IDLE (global conflict)
//   sig, lamp    : registered pedestrian signal code and hand-lamp drive
//   pending      : registered request latch
module ped_channel
  import tlc_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = 6,
  parameter int unsigned FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       btn,
  input  logic       force_idle,
  output logic [1:0] sig,
  output logic       lamp,
  output logic       pending
);

  localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);

  chan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  prev_light_q, prev_light_d;
  logic        pending_q, pending_d;
  logic [1:0]  sig_q, sig_d;
  logic        lamp_q, lamp_d;
  logic        green_s;
  logic        onset_s;

  assign green_s = (light == LIGHT_GREEN);
  assign onset_s = green_s && (prev_light_q != LIGHT_GREEN);

  // Next-state, counter, request latch and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q | btn;
    prev_light_d = light;
    sig_d        = PED_DONT_WALK;
    lamp_d       = 1'b1;

    if (force_idle) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A press on the onset edge itself is served without ever latching.
          if (onset_s && (pending_q || btn)) begin
            state_d   = ST_WALK;
            cnt_d     = WALK_LOAD;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WALK: begin
          if (!green_s) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_d = ST_FLASH;
            cnt_d   = FLASH_LOAD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_FLASH: begin
          if (!green_s || (cnt_q == 4'd0)) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // Outputs follow the next state so they register in the same edge.
    case (state_d)
      ST_WALK: begin
        sig_d  = PED_WALK;
        lamp_d = 1'b0;
      end
      ST_FLASH: begin
        sig_d  = PED_FLASH;
        lamp_d = (state_q == ST_FLASH) ? ~lamp_q : 1'b1;
      end
      default: begin
        sig_d  = PED_DONT_WALK;
        lamp_d = 1'b1;
      end
    endcase
  end

  // Channel state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      prev_light_q <= LIGHT_RED;
      pending_q    <= 1'b0;
      sig_q        <= PED_DONT_WALK;
      lamp_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_light_q <= prev_light_d;
      pending_q    <= pending_d;
      sig_q        <= sig_d;
      lamp_q       <= lamp_d;
    end
  end

  assign sig     = sig_q;
  assign lamp    = lamp_q;
  assign pending = pending_q;

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian crosswalk signal stage downstream of the vehicle light controller.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : slave side of ped_signal_controller_if (lights and buttons in,
//           crosswalk signals, lamps, pending flags and conflict_err out)
// Holds the sticky conflict detector; each crosswalk is a ped_channel.
module ped_signal_controller
  import tlc_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = 6,
  parameter int unsigned FLASH_CYCLES = 4
) (
  input logic                     clk,
  input logic                     reset,
  ped_signal_controller_if.slave  bus
);

  logic conflict_q, conflict_d;
  logic conflict_s;
  logic force_idle_s;

  // Sticky conflict flag; the current-cycle detection forces idle immediately
  // so both signals drop on the same edge that sets the flag.
  always_comb begin
    conflict_s   = is_conflict(bus.ns_light, bus.ew_light);
    conflict_d   = conflict_q | conflict_s;
    force_idle_s = conflict_d;
  end

  // Conflict flag register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  ped_channel #(
    .WALK_CYCLES  (WALK_CYCLES),
    .FLASH_CYCLES (FLASH_CYCLES)
  ) u_ns_channel (
    .clk        (clk),
    .reset      (reset),
    .light      (bus.ns_light),
    .btn        (bus.ns_ped_btn),
    .force_idle (force_idle_s),
    .sig        (bus.ns_ped_sig),
    .lamp       (bus.ns_ped_lamp),
    .pending    (bus.ns_req_pending)
  );

  ped_channel #(
    .WALK_CYCLES  (WALK_CYCLES),
    .FLASH_CYCLES (FLASH_CYCLES)
  ) u_ew_channel (
    .clk        (clk),
    .reset      (reset),
    .light      (bus.ew_light),
    .btn        (bus.ew_ped_btn),
    .force_idle (force_idle_s),
    .sig        (bus.ew_ped_sig),
    .lamp       (bus.ew_ped_lamp),
    .pending    (bus.ew_req_pending)
  );

  assign bus.conflict_err = conflict_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed self-checking bench for ped_signal_controller (default timing 6/4).
module tb_ped_signal_controller;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  ped_signal_controller_if bus ();

  ped_signal_controller #(
    .WALK_CYCLES  (6),
    .FLASH_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared = n_compared + 1;
    if (obs !== exp) begin
      n_mismatched = n_mismatched + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_value({tag, "_ns_sig"},  {6'd0, bus.ns_ped_sig}, 8'h00);
    check_value({tag, "_ew_sig"},  {6'd0, bus.ew_ped_sig}, 8'h00);
    check_value({tag, "_ns_lamp"}, {7'd0, bus.ns_ped_lamp}, 8'h01);
    check_value({tag, "_ew_lamp"}, {7'd0, bus.ew_ped_lamp}, 8'h01);
    check_value({tag, "_ns_pend"}, {7'd0, bus.ns_req_pending}, 8'h00);
    check_value({tag, "_ew_pend"}, {7'd0, bus.ew_req_pending}, 8'h00);
    check_value({tag, "_conflict"}, {7'd0, bus.conflict_err}, 8'h00);
  endtask

  initial begin
    logic [7:0] flash_lamp_exp [4];
    flash_lamp_exp[0] = 8'h01;
    flash_lamp_exp[1] = 8'h00;
    flash_lamp_exp[2] = 8'h01;
    flash_lamp_exp[3] = 8'h00;
    n_compared   = 0;
    n_mismatched = 0;
    reset          = 1'b0;
    bus.ns_light   = 2'b00;
    bus.ew_light   = 2'b00;
    bus.ns_ped_btn = 1'b0;
    bus.ew_ped_btn = 1'b0;
    #2;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b1;
    step();

    // 1) Press during EW green, served at next NS green onset.
    bus.ew_light = 2'b10;
    step();
    bus.ns_ped_btn = 1'b1;
    step();
    check_value("t1_pend_set", {7'd0, bus.ns_req_pending}, 8'h01);
    bus.ns_ped_btn = 1'b0;
    step();
    check_value("t1_pend_hold", {7'd0, bus.ns_req_pending}, 8'h01);
    check_value("t1_ew_no_walk", {6'd0, bus.ew_ped_sig}, 8'h00);
    bus.ew_light = 2'b01;
    step();
    bus.ew_light = 2'b00;
    step();
    check_value("t1_pend_red", {7'd0, bus.ns_req_pending}, 8'h01);
    bus.ns_light = 2'b10;
    step();
    check_value("t1_walk_first", {6'd0, bus.ns_ped_sig}, 8'h02);
    check_value("t1_walk_lamp", {7'd0, bus.ns_ped_lamp}, 8'h00);
    check_value("t1_pend_clr", {7'd0, bus.ns_req_pending}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("t1_walk", {6'd0, bus.ns_ped_sig}, 8'h02);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check_value("t1_flash", {6'd0, bus.ns_ped_sig}, 8'h01);
      check_value("t1_flash_lamp", {7'd0, bus.ns_ped_lamp}, flash_lamp_exp[i]);
    end
    step();
    check_value("t1_done_sig", {6'd0, bus.ns_ped_sig}, 8'h00);
    check_value("t1_done_lamp", {7'd0, bus.ns_ped_lamp}, 8'h01);
    bus.ns_light = 2'b01;
    step();
    bus.ns_light = 2'b00;
    step();

    // 2) Green onset with nothing pending: stays DON'T WALK.
    bus.ns_light = 2'b10;
    for (int i = 0; i < 11; i++) begin
      step();
      check_value("t2_no_req", {6'd0, bus.ns_ped_sig}, 8'h00);
    end
    bus.ns_light = 2'b01;
    step();
    bus.ns_light = 2'b00;
    step();

    // 3) Abort on the 3rd WALK cycle.
    bus.ns_ped_btn = 1'b1;
    step();
    bus.ns_ped_btn = 1'b0;
    bus.ns_light   = 2'b10;
    step();
    step();
    step();
    check_value("t3_walk3", {6'd0, bus.ns_ped_sig}, 8'h02);
    bus.ns_light = 2'b01;
    step();
    check_value("t3_abort_sig", {6'd0, bus.ns_ped_sig}, 8'h00);
    check_value("t3_abort_pend", {7'd0, bus.ns_req_pending}, 8'h00);
    bus.ns_light = 2'b00;
    step();

    // 4) Press and onset at the same edge.
    bus.ns_light   = 2'b10;
    bus.ns_ped_btn = 1'b1;
    step();
    bus.ns_ped_btn = 1'b0;
    check_value("t4_walk", {6'd0, bus.ns_ped_sig}, 8'h02);
    check_value("t4_pend0", {7'd0, bus.ns_req_pending}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("t4_pend_low", {7'd0, bus.ns_req_pending}, 8'h00);
    end
    bus.ns_light = 2'b01;
    step();
    bus.ns_light = 2'b00;
    step();

    // 5) Both green: sticky conflict, channels held idle, latches still work.
    bus.ns_light   = 2'b10;
    bus.ew_light   = 2'b10;
    bus.ns_ped_btn = 1'b1;
    step();
    bus.ns_ped_btn = 1'b0;
    check_value("t5_conflict", {7'd0, bus.conflict_err}, 8'h01);
    check_value("t5_ns_sig", {6'd0, bus.ns_ped_sig}, 8'h00);
    check_value("t5_ew_sig", {6'd0, bus.ew_ped_sig}, 8'h00);
    check_value("t5_pend_latch", {7'd0, bus.ns_req_pending}, 8'h01);
    bus.ns_light = 2'b00;
    bus.ew_light = 2'b00;
    step();
    bus.ns_light = 2'b10;
    step();
    check_value("t5_sticky", {7'd0, bus.conflict_err}, 8'h01);
    check_value("t5_held_idle", {6'd0, bus.ns_ped_sig}, 8'h00);
    reset        = 1'b0;
    bus.ns_light = 2'b00;
    step();
    check_reset_values("t5_reset");
    reset = 1'b1;
    step();

    // 5b) Single illegal code also trips the conflict.
    bus.ew_light = 2'b11;
    step();
    check_value("t5b_illegal", {7'd0, bus.conflict_err}, 8'h01);
    reset        = 1'b0;
    bus.ew_light = 2'b00;
    step();
    reset = 1'b1;
    step();
    check_value("t5b_cleared", {7'd0, bus.conflict_err}, 8'h00);

    // 6) Reset mid-FLASH with EW pending.
    bus.ns_ped_btn = 1'b1;
    step();
    bus.ns_ped_btn = 1'b0;
    bus.ns_light   = 2'b10;
    step();
    bus.ew_ped_btn = 1'b1;
    step();
    bus.ew_ped_btn = 1'b0;
    check_value("t6_ew_pend", {7'd0, bus.ew_req_pending}, 8'h01);
    for (int i = 0; i < 5; i++) step();
    check_value("t6_flash", {6'd0, bus.ns_ped_sig}, 8'h01);
    reset = 1'b0;
    step();
    check_reset_values("t6_reset");
    bus.ns_light = 2'b00;
    reset        = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
